// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: APB2 write-only master that programs a PWM period once, then ramps on_limit.
// Latency: first setup phase one pclk after enable; update setups follow max(interval,1) cycles after each write.
// Backpressure: access phases stretch until pready; PWM_SEQ_TIMEOUT_EN bounds the stretch to TIMEOUT_CYCLES.
//
// Optional feature macro: PWM_SEQ_TIMEOUT_EN (access-phase timeout with sticky err).
//
// Ports:
//   pclk, preset_n            clock, asynchronous active-low reset
//   enable                    level-sensitive run request
//   period, max_level, step,  configuration, captured on the edge that leaves IDLE
//   interval
//   psel, penable, pwrite,    APB2 master outputs (registered); pstrb/pprot are constants
//   paddr, pwdata, pstrb,
//   pprot
//   pready, prdata            APB2 slave response; prdata is ignored (write-only master)
//   busy                      high whenever the FSM is not IDLE
//   level                     current on_limit value
//   err                       sticky transfer-timeout flag (tied low without the timeout feature)
module pwm_ramp_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic [31:0] max_level,
  input  logic [31:0] step,
  input  logic [23:0] interval,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [7:0]  paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  output logic [2:0]  pprot,
  input  logic        pready,
  input  logic [31:0] prdata,
  output logic        busy,
  output logic [31:0] level,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    INIT_SETUP  = 3'd1,
    INIT_ACCESS = 3'd2,
    UPD_SETUP   = 3'd3,
    UPD_ACCESS  = 3'd4,
    WAIT        = 3'd5,
    OFF_SETUP   = 3'd6,
    OFF_ACCESS  = 3'd7
  } state_t;

  localparam logic [7:0] ADDR_LIMIT = 8'h00;  // counter_limit register
  localparam logic [7:0] ADDR_ON    = 8'h04;  // on_limit register

  state_t      state;
  logic [31:0] max_q;
  logic [31:0] step_q;
  logic [23:0] wait_len_q;   // interval with 0 promoted to 1
  logic [23:0] wait_cnt;
  logic        dir_down;
  logic        stop_req;     // enable seen low during a transfer; honoured once it completes

  logic [32:0] up_sum;
  logic [31:0] next_level;
  logic        next_dir_down;

  assign pstrb = 4'hF;
  assign pprot = 3'b000;

  // Reads are never issued, so prdata is intentionally unused.
  logic unused_ok;
  assign unused_ok = ^{prdata, 32'(TIMEOUT_CYCLES)};

`ifdef PWM_SEQ_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic        err_q;
  logic [31:0] tmo_cnt;      // access cycles already spent without pready
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next ramp point. The up-step compares in 33 bits so a large step cannot wrap
  // past max_level; step=0 freezes both level and direction.
  always_comb begin
    up_sum        = {1'b0, level} + {1'b0, step_q};
    next_level    = level;
    next_dir_down = dir_down;
    if (step_q != 32'd0) begin
      if (!dir_down) begin
        if (up_sum >= {1'b0, max_q}) begin
          next_level    = max_q;
          next_dir_down = 1'b1;
        end else begin
          next_level = up_sum[31:0];
        end
      end else begin
        if (level <= step_q) begin
          next_level    = 32'd0;
          next_dir_down = 1'b0;
        end else begin
          next_level = level - step_q;
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state      <= IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= 8'h00;
      pwdata     <= 32'd0;
      busy       <= 1'b0;
      level      <= 32'd0;
      dir_down   <= 1'b0;
      wait_cnt   <= 24'd0;
      stop_req   <= 1'b0;
      max_q      <= 32'd0;
      step_q     <= 32'd0;
      wait_len_q <= 24'd1;
`ifdef PWM_SEQ_TIMEOUT_EN
      err_q      <= 1'b0;
      tmo_cnt    <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            max_q      <= max_level;
            step_q     <= step;
            wait_len_q <= (interval == 24'd0) ? 24'd1 : interval;
            stop_req   <= 1'b0;
            state      <= INIT_SETUP;
            psel       <= 1'b1;
            penable    <= 1'b0;
            pwrite     <= 1'b1;
            paddr      <= ADDR_LIMIT;
            pwdata     <= period;    // pwdata itself holds the captured period
            busy       <= 1'b1;
          end
        end

        INIT_SETUP, UPD_SETUP, OFF_SETUP: begin
          penable <= 1'b1;
          if (!enable) stop_req <= 1'b1;
          if (state == INIT_SETUP)     state <= INIT_ACCESS;
          else if (state == UPD_SETUP) state <= UPD_ACCESS;
          else                         state <= OFF_ACCESS;
`ifdef PWM_SEQ_TIMEOUT_EN
          tmo_cnt <= 32'd0;
`endif
        end

        INIT_ACCESS, UPD_ACCESS, OFF_ACCESS: begin
          if (!enable) stop_req <= 1'b1;
          if (pready) begin
            if (state == OFF_ACCESS) begin
              state    <= IDLE;
              psel     <= 1'b0;
              penable  <= 1'b0;
              pwrite   <= 1'b0;
              paddr    <= 8'h00;
              pwdata   <= 32'd0;
              busy     <= 1'b0;
              level    <= 32'd0;
              dir_down <= 1'b0;
              stop_req <= 1'b0;
            end else if (stop_req || !enable) begin
              // Back-to-back into the off write; psel/pwrite stay high.
              state    <= OFF_SETUP;
              penable  <= 1'b0;
              paddr    <= ADDR_ON;
              pwdata   <= 32'd0;
              stop_req <= 1'b0;
            end else if (state == INIT_ACCESS) begin
              state    <= UPD_SETUP;
              penable  <= 1'b0;
              paddr    <= ADDR_ON;
              pwdata   <= 32'd0;
              level    <= 32'd0;
              dir_down <= 1'b0;
            end else begin
              state    <= WAIT;
              psel     <= 1'b0;
              penable  <= 1'b0;
              pwrite   <= 1'b0;
              paddr    <= 8'h00;
              pwdata   <= 32'd0;
              wait_cnt <= wait_len_q;
            end
          end
`ifdef PWM_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            // Abandon the transfer; it is not retried and err stays set until reset.
            state    <= IDLE;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= 8'h00;
            pwdata   <= 32'd0;
            busy     <= 1'b0;
            stop_req <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
`endif
        end

        WAIT: begin
          if (!enable) begin
            state   <= OFF_SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= 1'b1;
            paddr   <= ADDR_ON;
            pwdata  <= 32'd0;
          end else if (wait_cnt <= 24'd1) begin
            state    <= UPD_SETUP;
            psel     <= 1'b1;
            penable  <= 1'b0;
            pwrite   <= 1'b1;
            paddr    <= ADDR_ON;
            pwdata   <= next_level;
            level    <= next_level;
            dir_down <= next_dir_down;
            wait_cnt <= 24'd0;
          end else begin
            wait_cnt <= wait_cnt - 24'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb_pwm_ramp_sequencer: randomized APB-slave bench for pwm_ramp_sequencer with a ramp reference model.
// Latency: n/a (testbench).
// Backpressure: the slave model inserts random or fixed wait states, or holds pready low.
module tb_pwm_ramp_sequencer;

  localparam int TMO = 16;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        enable;
  logic [31:0] period, max_level, step;
  logic [23:0] interval;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'd0;
  logic        busy;
  logic [31:0] level;
  logic        err;

  pwm_ramp_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .preset_n(preset_n), .enable(enable),
    .period(period), .max_level(max_level), .step(step), .interval(interval),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .pready(pready), .prdata(prdata),
    .busy(busy), .level(level), .err(err)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge pclk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- APB slave model ----------------
  int pr_lo = 0, pr_hi = 0;
  bit pr_stuck = 1'b0;
  int wait_left = 0;

  always @(posedge pclk) begin
    #1;
    prdata = $urandom;
    if (psel && !penable) begin
      wait_left = pr_stuck ? -1 : int'($urandom_range(pr_hi, pr_lo));
      pready = 1'b0;
    end else if (psel && penable) begin
      pready = (wait_left == 0);
      if (wait_left > 0) wait_left--;
    end else begin
      pready = 1'b0;
    end
  end

  // ---------------- bus monitor ----------------
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          setup_cyc;
    int          done_cyc;
    int          acc_len;
  } wr_t;

  wr_t         wr_q[$];
  logic [7:0]  s_addr;
  logic [31:0] s_data;
  int          s_cyc, acc_n;
  bit          in_xfer = 1'b0;

  always @(negedge pclk) begin
    if (!preset_n) begin
      in_xfer = 1'b0;
    end else if (psel && !penable) begin
      check_eq("setup_after_done", 64'(in_xfer), 64'd0);
      check_eq("setup_ctrl", {pwrite, pstrb, pprot}, {1'b1, 4'hF, 3'b000});
      s_addr  = paddr;
      s_data  = pwdata;
      s_cyc   = cyc;
      acc_n   = 0;
      in_xfer = 1'b1;
    end else if (psel && penable) begin
      acc_n++;
      check_eq("access_has_setup", 64'(in_xfer), 64'd1);
      check_eq("access_hold", {pwrite, paddr, pwdata}, {1'b1, s_addr, s_data});
      if (pready) begin
        wr_q.push_back('{s_addr, s_data, s_cyc, cyc, acc_n});
        in_xfer = 1'b0;
      end
    end else begin
      in_xfer = 1'b0;
      check_eq("idle_bus", {penable, pwrite, paddr, pwdata}, 64'd0);
    end
  end

  // ---------------- reference model ----------------
  // Expected on_limit sequence: starts at 0, rises by step until it reaches
  // max_level, then falls by step to 0, and repeats.
  logic [31:0] exp_q[$];

  task automatic build_ramp(input longint mx, input longint st, input int n);
    longint lv = 0;
    bit     up = 1'b1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(lv[31:0]);
      if (st != 0) begin
        if (up) begin
          if (lv + st >= mx) begin lv = mx; up = 1'b0; end
          else lv = lv + st;
        end else begin
          if (lv <= st) begin lv = 0; up = 1'b1; end
          else lv = lv - st;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy; i++) tick();
    check_eq({tag, "_busy_clear"}, 64'(busy), 64'd0);
  endtask

  // One start/ramp/stop episode. Called at posedge+1.
  task automatic run_case(input string name, input logic [31:0] per, input logic [31:0] mx,
                          input logic [31:0] st, input logic [23:0] iv, input int wlo,
                          input int whi, input int nwr, input bit drop_acc);
    int drop, n, nreg, w;
    wr_q.delete();
    pr_lo = wlo; pr_hi = whi; pr_stuck = 1'b0;
    period = per; max_level = mx; step = st; interval = iv;
    enable = 1'b1;
    tick();
    // Configuration was captured on the edge just taken; later changes must not matter.
    period = $urandom; max_level = $urandom; step = $urandom; interval = 24'($urandom);
    for (int i = 0; i < 4000 && wr_q.size() < nwr; i++) tick();
    if (drop_acc)
      for (int i = 0; i < 200 && !(psel && penable && paddr == 8'h04); i++) tick();
    enable = 1'b0;
    drop = cyc;
    wait_idle(name);
    check_eq({name, "_level_zero"}, 64'(level), 64'd0);

    n = wr_q.size();
    w = (iv == 24'd0) ? 1 : int'(iv);
    check_eq({name, "_enough_writes"}, 64'(n >= 2), 64'd1);
    if (n >= 2) begin
      nreg = 0;
      foreach (wr_q[i]) if (wr_q[i].setup_cyc <= drop) nreg++;
      check_eq({name, "_single_off_write"}, 64'(n - nreg), 64'd1);
      build_ramp(longint'(mx), longint'(st), nreg);
      check_eq({name, "_init_write"}, {wr_q[0].addr, wr_q[0].data}, {8'h00, per});
      for (int i = 1; i < nreg; i++) begin
        check_eq({name, "_upd_write"}, {wr_q[i].addr, wr_q[i].data}, {8'h04, exp_q[i - 1]});
        check_eq({name, "_upd_gap"}, 64'(wr_q[i].setup_cyc - wr_q[i - 1].done_cyc),
                 64'((i == 1) ? 1 : w + 1));
      end
      check_eq({name, "_off_write"}, {wr_q[n - 1].addr, wr_q[n - 1].data}, {8'h04, 32'd0});
      foreach (wr_q[i])
        check_eq({name, "_access_len"},
                 64'(wr_q[i].acc_len >= wlo + 1 && wr_q[i].acc_len <= whi + 1), 64'd1);
    end
  endtask

  logic [31:0] ramp_tbl [8];
  int          n_acc;

  initial begin
    preset_n = 1'b0; enable = 1'b0;
    period = '0; max_level = '0; step = '0; interval = '0;
    ramp_tbl = '{32'd0, 32'd4, 32'd8, 32'd10, 32'd6, 32'd2, 32'd0, 32'd4};

    repeat (3) @(posedge pclk);
    #1;
    check_eq("rst_apb_ctrl", {psel, penable, pwrite}, 64'd0);
    check_eq("rst_paddr", 64'(paddr), 64'd0);
    check_eq("rst_pwdata", 64'(pwdata), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_level", 64'(level), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("const_pstrb_pprot", {pstrb, pprot}, {4'hF, 3'b000});
    preset_n = 1'b1;
    tick();

    // Reference ramp, single-cycle access phases.
    run_case("ramp", 32'd100, 32'd10, 32'd4, 24'd3, 0, 0, 9, 1'b0);
    for (int i = 0; i < 8; i++)
      check_eq("ramp_table", (i + 1 < wr_q.size()) ? 64'(wr_q[i + 1].data) : 64'hx,
               64'(ramp_tbl[i]));
    if (wr_q.size() > 3)
      check_eq("ramp_setup_spacing", 64'(wr_q[3].setup_cyc - wr_q[2].setup_cyc), 64'd5);

    // Three extra wait states on every access, stop while an update is in its access phase.
    run_case("wstate", 32'd200, 32'd30, 32'd7, 24'd2, 3, 3, 4, 1'b1);

    // Edge configurations.
    run_case("step0", 32'd50, 32'd50, 32'd0, 24'd2, 0, 1, 6, 1'b0);
    run_case("max0", 32'd60, 32'd0, 32'd5, 24'd1, 0, 1, 6, 1'b0);
    run_case("ival0", 32'd70, 32'd9, 32'd3, 24'd0, 0, 0, 7, 1'b0);
    run_case("bigstep", 32'd80, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 24'd1, 0, 0, 5, 1'b0);

    // Randomized episodes.
    for (int k = 0; k < 12; k++)
      run_case("rnd", 32'($urandom_range(1000)), 32'($urandom_range(60)),
               32'($urandom_range(20)), 24'($urandom_range(4)), 0, int'($urandom_range(2)),
               int'($urandom_range(14, 2)), 1'($urandom_range(1)));

    // Reset in the middle of the period write, then restart.
    wr_q.delete();
    pr_stuck = 1'b1;
    period = 32'd77; max_level = 32'd20; step = 32'd3; interval = 24'd2;
    enable = 1'b1;
    for (int i = 0; i < 50 && !(psel && penable && paddr == 8'h00); i++) tick();
    check_eq("rst_mid_reached_access", {psel, penable, paddr}, {1'b1, 1'b1, 8'h00});
    #2 preset_n = 1'b0;
    #1;
    check_eq("rst_mid_apb_ctrl", {psel, penable, pwrite}, 64'd0);
    check_eq("rst_mid_bus", {paddr, pwdata}, 64'd0);
    check_eq("rst_mid_status", {busy, err, level}, 64'd0);
    pr_stuck = 1'b0; pr_lo = 0; pr_hi = 0;
    tick();
    preset_n = 1'b1;
    for (int i = 0; i < 100 && wr_q.size() < 2; i++) tick();
    check_eq("restart_writes", 64'(wr_q.size() >= 2), 64'd1);
    if (wr_q.size() >= 2) begin
      check_eq("restart_init", {wr_q[0].addr, wr_q[0].data}, {8'h00, 32'd77});
      check_eq("restart_first_upd", {wr_q[1].addr, wr_q[1].data}, {8'h04, 32'd0});
    end
    enable = 1'b0;
    wait_idle("restart");

    // Slave never answers.
    pr_stuck = 1'b1;
    period = 32'd5; max_level = 32'd8; step = 32'd2; interval = 24'd1;
    enable = 1'b1;
    for (int i = 0; i < 20 && !(psel && penable); i++) tick();
    n_acc = 0;
    while (psel && penable && n_acc < 40) begin
      n_acc++;
      tick();
    end
`ifdef PWM_SEQ_TIMEOUT_EN
    check_eq("tmo_access_cycles", 64'(n_acc), 64'(TMO));
    check_eq("tmo_abort_state", {psel, penable, busy, err}, {1'b0, 1'b0, 1'b0, 1'b1});
    enable = 1'b0;
    tick();
    check_eq("tmo_err_sticky", {busy, err}, {1'b0, 1'b1});
`else
    check_eq("no_tmo_access_cycles", 64'(n_acc), 64'd40);
    check_eq("no_tmo_still_waiting", {psel, penable, busy, err}, {1'b1, 1'b1, 1'b1, 1'b0});
    enable = 1'b0;
    tick();
`endif
    preset_n = 1'b0;
    tick();
    preset_n = 1'b1;
    pr_stuck = 1'b0;
    check_eq("err_cleared_by_reset", {busy, err}, 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
